seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
Time-multiplexes one shared segment_decoder across the four digits of the board's common-anode 7-segment display. The block sequences digit selection and anode drive, inserts an anti-ghosting blank interval between digits, suppresses leading zeros, and holds a tear-free per-frame snapshot of the 16-bit value from the up/down counter datapath. Its outputs drive the decoder's digit input and the anode pins directly.

Parameters:
TICK_DIV, 100000, clk cycles per digit slot (blank + show); must be >= 2
BLANK_CYCLES, 1000, cycles of each slot with all anodes off; 1 <= BLANK_CYCLES < TICK_DIV

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  scan enable; 0 = display dark
digits_in  input  16  four BCD/hex nibbles; [3:0] = digit0 (rightmost), [15:12] = digit3
dp_in  input  4  decimal point request per digit, active-high
blank_lz  input  1  1 = suppress leading zeros
digit_val  output  4  nibble to segment_decoder for the current slot
digit_sel  output  2  index of the current slot, 0..3
anodes  output  4  active-low anode enables; bit i = digit i
dp_n  output  1  active-low decimal point segment
frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Reset and interface: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: anodes=4'b1111, digit_val=0, digit_sel=0, dp_n=1, frame_done=0, state=IDLE, slot counter cnt=0, snapshot=0.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - anodes=1111.
  - If en=1, the next edge enters BLANK with digit_sel=0 and cnt=0, and loads snapshot<=digits_in and dp snapshot<=dp_in.
- BLANK:
  - Occupies cnt=0..BLANK_CYCLES-1 with anodes=1111.
  - digit_val and dp_n are updated on BLANK entry so the decoder output settles before the anode turns on.
  - At cnt=BLANK_CYCLES-1, transition to SHOW.
- SHOW:
  - Occupies cnt=BLANK_CYCLES..TICK_DIV-1.
  - anodes = all ones except bit digit_sel=0, unless that digit is suppressed; a suppressed digit keeps anodes=1111.
  - dp_n = ~dp_snapshot[digit_sel].
  - At cnt=TICK_DIV-1: cnt<=0, digit_sel<=digit_sel+1 (wraps 3->0), next state BLANK.
  - If digit_sel was 3, that same cycle frame_done=1 and the snapshot reloads from digits_in/dp_in.
- Slot length: each slot is exactly TICK_DIV cycles; a frame is 4*TICK_DIV cycles.
- Leading-zero suppression (blank_lz=1):
  - Digit i (i=3..1) is suppressed iff its snapshot nibble and every higher nibble are 0.
  - Digit 0 is never suppressed.
  - The decision uses the snapshot, not live inputs.
- Snapshot: digits_in changes mid-frame never affect the current frame.
- en deasserted in any state: the next edge enters IDLE, anodes=1111, digit_sel=0, cnt=0, and frame_done stays 0. Re-enabling always restarts at digit 0 with BLANK.
- reset asserted mid-frame: the next edge applies all reset values; reset overrides en.
- Counter width: cnt is $clog2(TICK_DIV) bits and never exceeds TICK_DIV-1.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4
  - ANODE_OFF=4'b1111
  - the state enum {IDLE, BLANK, SHOW}
  - a function computing the suppression mask from a 16-bit value and blank_lz
- Sub-module seg7_slot_timer(TICK_DIV, BLANK_CYCLES) contains cnt and emits two strobes:
  - blank_end at cnt=BLANK_CYCLES-1
  - slot_end at cnt=TICK_DIV-1
  - clear input forces cnt=0
- The top level holds the FSM, digit_sel, the snapshot and the output registers.

Test Plan:
All scenarios use TICK_DIV=8 and BLANK_CYCLES=2.
1. Reset held 3 cycles with en=1 -> anodes=1111, dp_n=1, digit_val=0, digit_sel=0, frame_done=0 throughout; the cycle after release is still IDLE/1111.
2. en=1, digits_in=16'h1234, blank_lz=0 -> per slot, 2 cycles of anodes=1111 then 6 cycles of anodes=1110 with digit_val=4; then 1101/3, 1011/2, 0111/1; frame_done pulses every 32 cycles.
3. blank_lz=1, digits_in=16'h0050:
   - digit3 and digit2 slots keep anodes=1111; digit1 shows 5; digit0 shows 0.
   - With 16'h0000, only digit0 lights, showing 0.
   - With blank_lz=0, all four digits light.
4. Change digits_in from 16'h1234 to 16'hABCD during the digit1 slot -> the rest of that frame still shows 2 and 1; the frame after frame_done shows D, C, B, A.
5. dp_in=4'b0100 -> dp_n=0 only during the digit2 slot, 1 otherwise.
6. Drop en during a SHOW cycle -> anodes=1111 on the next edge and stays dark. Re-raise en -> the next slot is digit0, starting with 2 blank cycles. Assert reset mid-frame -> reset values on the next edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and digit helpers for the 7-segment scan controller.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
  localparam int unsigned SEL_W      = 2;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Bit i set when digit i is a leading zero; digit 0 always stays visible.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] val,
                                                    input logic              blank_lz);
    logic [NUM_DIGITS-1:0] m;
    m = '0;
    if (blank_lz) begin
      m[3] = (val[15:12] == 4'h0);
      m[2] = m[3] && (val[11:8] == 4'h0);
      m[1] = m[2] && (val[7:4] == 4'h0);
    end
    return m;
  endfunction

  // Nibble idx of a packed 4-digit value.
  function automatic logic [NIB_W-1:0] get_nibble(input logic [DATA_W-1:0] val,
                                                  input logic [SEL_W-1:0]  idx);
    return val[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Value/control inputs and display-side outputs of the scan controller.
interface seg7_scan_controller_if;
  import seg7_pkg::*;

  logic                  en;
  logic [DATA_W-1:0]     digits_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank_lz;
  logic [NIB_W-1:0]      digit_val;
  logic [SEL_W-1:0]      digit_sel;
  logic [NUM_DIGITS-1:0] anodes;
  logic                  dp_n;
  logic                  frame_done;

  modport master (
    output en, digits_in, dp_in, blank_lz,
    input  digit_val, digit_sel, anodes, dp_n, frame_done
  );

  modport slave (
    input  en, digits_in, dp_in, blank_lz,
    output digit_val, digit_sel, anodes, dp_n, frame_done
  );
endinterface

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter with end-of-blank and end-of-slot strobes.
module seg7_slot_timer #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end  = (cnt == CW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap; clear holds the counter at zero.
  always_ff @(posedge clk) begin
    if (reset || clear || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 4-digit common-anode display scanner with blanking,
// leading-zero suppression and a per-frame value snapshot.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   reset,
  seg7_scan_controller_if.slave bus
);

  state_t                state;
  logic [DATA_W-1:0]     snap;
  logic [NUM_DIGITS-1:0] dp_snap;
  logic                  blank_end;
  logic                  slot_end;
  logic                  timer_clear;
  logic [SEL_W-1:0]      next_sel;
  logic [NUM_DIGITS-1:0] sup_mask;

  assign timer_clear = !bus.en || (state == IDLE);
  assign next_sel    = bus.digit_sel + SEL_W'(1);
  assign sup_mask    = lz_mask(snap, bus.blank_lz);

  seg7_slot_timer #(
    .TICK_DIV     (TICK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // Scan FSM; digit_val/dp_n are loaded on BLANK entry so the decoder settles before the anode lights.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      snap           <= '0;
      dp_snap        <= '0;
      bus.anodes     <= ANODE_OFF;
      bus.digit_val  <= '0;
      bus.digit_sel  <= '0;
      bus.dp_n       <= 1'b1;
      bus.frame_done <= 1'b0;
    end else if (!bus.en) begin
      state          <= IDLE;
      bus.anodes     <= ANODE_OFF;
      bus.digit_val  <= '0;
      bus.digit_sel  <= '0;
      bus.dp_n       <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state         <= BLANK;
          snap          <= bus.digits_in;
          dp_snap       <= bus.dp_in;
          bus.anodes    <= ANODE_OFF;
          bus.digit_sel <= '0;
          bus.digit_val <= get_nibble(bus.digits_in, '0);
          bus.dp_n      <= ~bus.dp_in[0];
        end
        BLANK: begin
          if (blank_end) begin
            state      <= SHOW;
            bus.anodes <= sup_mask[bus.digit_sel] ? ANODE_OFF
                                                  : ~(NUM_DIGITS'(1) << bus.digit_sel);
          end
        end
        SHOW: begin
          if (slot_end) begin
            state         <= BLANK;
            bus.anodes    <= ANODE_OFF;
            bus.digit_sel <= next_sel;
            if (bus.digit_sel == SEL_W'(NUM_DIGITS - 1)) begin
              // Frame boundary: take a fresh snapshot and start digit 0 from it.
              snap           <= bus.digits_in;
              dp_snap        <= bus.dp_in;
              bus.frame_done <= 1'b1;
              bus.digit_val  <= get_nibble(bus.digits_in, '0);
              bus.dp_n       <= ~bus.dp_in[0];
            end else begin
              bus.digit_val <= get_nibble(snap, next_sel);
              bus.dp_n      <= ~dp_snap[next_sel];
            end
          end
        end
        default: begin
          state      <= IDLE;
          bus.anodes <= ANODE_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized self-checking bench for seg7_scan_controller against a frame/slot timing model.
module tb_seg7_scan_controller;

  localparam int TICK  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * TICK;

  logic clk;
  logic reset;

  seg7_scan_controller_if bus ();

  seg7_scan_controller #(
    .TICK_DIV     (TICK),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since scanning started, plus the frame snapshot.
  bit          started = 1'b0;
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_dp = '0;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset || !bus.en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t      = 0;
      m_snap   = bus.digits_in;
      m_dp     = bus.dp_in;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_snap = bus.digits_in;
        m_dp   = bus.dp_in;
      end
    end
  end

  always @(negedge clk) begin
    int   slot, phase;
    logic [15:0] upper;
    bit   sup;
    logic [3:0] exp_an;
    if (started) begin
      if (!m_active) begin
        check("anodes_idle", 16'(bus.anodes), 16'hF);
        check("sel_idle", 16'(bus.digit_sel), 16'd0);
        check("frame_done_idle", 16'(bus.frame_done), 16'd0);
        check("dp_n_idle", 16'(bus.dp_n), 16'd1);
        check("digit_val_idle", 16'(bus.digit_val), 16'd0);
      end else begin
        slot   = (m_t / TICK) % 4;
        phase  = m_t % TICK;
        upper  = m_snap >> (4 * slot);
        sup    = bus.blank_lz && (slot != 0) && (upper == 16'd0);
        exp_an = (phase < BLANK || sup) ? 4'hF : (4'hF & ~(4'd1 << slot));
        check("anodes", 16'(bus.anodes), 16'(exp_an));
        check("digit_sel", 16'(bus.digit_sel), 16'(slot));
        check("digit_val", 16'(bus.digit_val), upper & 16'hF);
        check("dp_n", 16'(bus.dp_n), 16'(!m_dp[slot]));
        check("frame_done", 16'(bus.frame_done), 16'((m_t % FRAME == 0) && (m_t != 0)));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b1;
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'b0000;
    bus.blank_lz  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2 * FRAME + 5);

    // Leading-zero suppression cases; blank_lz only changes while dark.
    bus.en = 1'b0; tick(2);
    bus.blank_lz = 1'b1; bus.digits_in = 16'h0050;
    bus.en = 1'b1; tick(FRAME + 4);
    bus.en = 1'b0; tick(2);
    bus.digits_in = 16'h0000;
    bus.en = 1'b1; tick(FRAME + 4);
    bus.en = 1'b0; tick(2);
    bus.blank_lz = 1'b0;
    bus.en = 1'b1; tick(FRAME);

    // Mid-frame value change during the digit1 slot.
    bus.en = 1'b0; tick(2);
    bus.digits_in = 16'h1234;
    bus.en = 1'b1; tick(TICK + 3);
    bus.digits_in = 16'hABCD; tick(2 * FRAME);

    // Decimal point on digit 2.
    bus.dp_in = 4'b0100; tick(2 * FRAME);

    // Drop en during SHOW, re-enable, then reset mid-frame.
    bus.en = 1'b0; tick(3);
    bus.en = 1'b1; tick(13);
    bus.en = 1'b0; tick(5);
    bus.en = 1'b1; tick(20);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(20);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      bus.digits_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bus.digits_in = bus.digits_in & 16'h00FF;
      bus.dp_in = 4'($urandom);
      case ($urandom_range(0, 5))
        0: begin
          bus.en = 1'b0; tick($urandom_range(1, 4));
          bus.blank_lz = 1'($urandom);
          bus.en = 1'b1;
        end
        1: begin
          reset = 1'b1; tick($urandom_range(1, 2));
          reset = 1'b0;
        end
        default: ;
      endcase
      tick($urandom_range(1, 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
